// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, ALU op/class codes, divider state enum and
// the request/result structs exchanged between ex_stage and div_iter.
package ex_stage_pkg;
  localparam int N_ALU_OP   = 8;
  localparam int N_ALU_SEL  = 3;
  localparam int N_REG      = 32;
  localparam int N_REG_ADDR = 5;

  localparam logic [N_ALU_OP-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [N_ALU_OP-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [N_ALU_OP-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [N_ALU_OP-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [N_ALU_OP-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [N_ALU_OP-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [N_ALU_OP-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [N_ALU_OP-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [N_ALU_OP-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [N_ALU_OP-1:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [N_ALU_SEL-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [N_ALU_SEL-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [N_ALU_SEL-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [N_ALU_SEL-1:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_DIV0 = 2'd1,
    DIV_BUSY = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic             signed_op;
    logic [N_REG-1:0] dividend;
    logic [N_REG-1:0] divisor;
  } div_req_t;

  typedef struct packed {
    logic [N_REG-1:0] hi;  // remainder
    logic [N_REG-1:0] lo;  // quotient
  } hilo_t;

  function automatic logic [N_REG-1:0] abs_val(logic [N_REG-1:0] v);
    return v[N_REG-1] ? -v : v;
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_if: decode->EX operand/control bundle and EX->mem/forwarding results.
//   i_* : alu op/class, operands, destination, flush (driven by decode side)
//   o_* : GPR write, HI/LO write, stall request (driven by ex_stage)
// master = decode/testbench side, slave = ex_stage.
interface ex_if;
  import ex_stage_pkg::*;
  logic [N_ALU_OP-1:0]   i_alu_op;
  logic [N_ALU_SEL-1:0]  i_alu_sel;
  logic [N_REG-1:0]      i_op_reg_0;
  logic [N_REG-1:0]      i_op_reg_1;
  logic                  i_reg_wen;
  logic [N_REG_ADDR-1:0] i_reg_waddr;
  logic                  i_flush;
  logic                  o_reg_wen;
  logic [N_REG_ADDR-1:0] o_reg_waddr;
  logic [N_REG-1:0]      o_reg_wdata;
  logic                  o_hilo_wen;
  logic [N_REG-1:0]      o_hi;
  logic [N_REG-1:0]      o_lo;
  logic                  o_stall_req;

  modport master (
    output i_alu_op, i_alu_sel, i_op_reg_0, i_op_reg_1, i_reg_wen, i_reg_waddr, i_flush,
    input  o_reg_wen, o_reg_waddr, o_reg_wdata, o_hilo_wen, o_hi, o_lo, o_stall_req
  );
  modport slave (
    input  i_alu_op, i_alu_sel, i_op_reg_0, i_op_reg_1, i_reg_wen, i_reg_waddr, i_flush,
    output o_reg_wen, o_reg_waddr, o_reg_wdata, o_hilo_wen, o_hi, o_lo, o_stall_req
  );
endinterface

// File: rtl/ex_stage_div_iter.sv
// div_iter: 32-step restoring divider (one step per cycle) on operand
// magnitudes, with sign fix-up applied on the result in DONE.
//   clk, rst  : clock, synchronous active-high reset
//   start     : accept req (only honoured in IDLE)
//   annul     : abandon whatever is in flight, back to IDLE next edge
//   req       : signed flag, dividend, divisor (latched on acceptance)
//   busy      : DIV0 or BUSY
//   done      : DONE and not annulled; res valid only while high
//   res       : hi = remainder, lo = quotient (0 when done is low)
module div_iter
  import ex_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  logic     annul,
  input  div_req_t req,
  output logic     busy,
  output logic     done,
  output hilo_t    res
);
  div_state_e       state, state_nxt;
  logic [4:0]       cnt;
  logic [N_REG-1:0] quo, rem, dvs;
  logic             neg_q, neg_r;
  logic [N_REG:0]   rem_sh, diff;

  // quo starts as the dividend magnitude; its MSBs shift into rem while
  // quotient bits shift in at the bottom.
  assign rem_sh = {rem, quo[N_REG-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = (req.divisor == '0) ? DIV_DIV0 : DIV_BUSY;
      DIV_DIV0: state_nxt = DIV_DONE;
      DIV_BUSY: if (cnt == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (annul) state_nxt = DIV_IDLE;
  end

  always_comb begin
    busy = (state == DIV_BUSY) || (state == DIV_DIV0);
    done = (state == DIV_DONE) && !annul;
    res  = '0;
    if (done) begin
      res.lo = neg_q ? -quo : quo;
      res.hi = neg_r ? -rem : rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start && !annul) begin
          cnt   <= '0;
          rem   <= '0;
          quo   <= req.signed_op ? abs_val(req.dividend) : req.dividend;
          dvs   <= req.signed_op ? abs_val(req.divisor)  : req.divisor;
          // quotient negative on sign mismatch, remainder follows dividend
          neg_q <= req.signed_op && (req.dividend[N_REG-1] ^ req.divisor[N_REG-1]);
          neg_r <= req.signed_op && req.dividend[N_REG-1];
        end
        DIV_DIV0: begin
          quo   <= '0;
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end
        DIV_BUSY: begin
          cnt <= cnt + 5'd1;
          if (!diff[N_REG]) begin
            rem <= diff[N_REG-1:0];
            quo <= {quo[N_REG-2:0], 1'b1};
          end else begin
            rem <= rem_sh[N_REG-1:0];
            quo <= {quo[N_REG-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Logic and shift results are combinational;
// DIV/DIVU run on the iterative divider and stall the front end.
//   i_clk, i_rst : clock, synchronous active-high reset
//   ex (slave)   : decode inputs, GPR/HILO write outputs, stall request
// Build option: EX_DIV_EN adds the divider; without it DIV/DIVU are NOPs
// and the stall/HILO outputs are tied low.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic i_clk,
  input logic i_rst,
  ex_if.slave ex
);
  logic [N_REG-1:0] logic_res, shift_res, wdata;
  logic [4:0]       sa;
  logic             wr_kill;
  logic             div_stall, div_hw;
  hilo_t            div_res;

  assign sa = ex.i_op_reg_0[4:0];

  always_comb begin
    logic_res = '0;
    case (ex.i_alu_op)
      EXE_OR_OP:  logic_res = ex.i_op_reg_0 | ex.i_op_reg_1;
      EXE_AND_OP: logic_res = ex.i_op_reg_0 & ex.i_op_reg_1;
      EXE_XOR_OP: logic_res = ex.i_op_reg_0 ^ ex.i_op_reg_1;
      EXE_NOR_OP: logic_res = ~(ex.i_op_reg_0 | ex.i_op_reg_1);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (ex.i_alu_op)
      EXE_SLL_OP: shift_res = ex.i_op_reg_1 << sa;
      EXE_SRL_OP: shift_res = ex.i_op_reg_1 >> sa;
      EXE_SRA_OP: shift_res = $signed(ex.i_op_reg_1) >>> sa;
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    case (ex.i_alu_sel)
      EXE_RES_LOGIC: wdata = logic_res;
      EXE_RES_SHIFT: wdata = shift_res;
      default:       wdata = '0;
    endcase
  end

  // ARITH results go to HI/LO, never to the GPR file
  assign wr_kill = ex.i_flush || (ex.i_alu_sel == EXE_RES_NOP) || (ex.i_alu_sel == EXE_RES_ARITH);

`ifdef EX_DIV_EN
  logic     is_div, annul, start, busy, done;
  div_req_t req;

  assign is_div = (ex.i_alu_op == EXE_DIV_OP) || (ex.i_alu_op == EXE_DIVU_OP);
  assign annul  = ex.i_flush | i_rst;
  // only IDLE accepts; the instruction still presented during DONE is not restarted
  assign start  = is_div && !annul && !busy && !done;
  assign req    = '{signed_op: (ex.i_alu_op == EXE_DIV_OP),
                    dividend:  ex.i_op_reg_0,
                    divisor:   ex.i_op_reg_1};

  div_iter u_div (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (start),
    .annul (annul),
    .req   (req),
    .busy  (busy),
    .done  (done),
    .res   (div_res)
  );

  assign div_stall = start | busy;
  assign div_hw    = done;
`else
  assign div_stall = 1'b0;
  assign div_hw    = 1'b0;
  assign div_res   = '0;
`endif

  assign ex.o_reg_wen   = !i_rst && !wr_kill && ex.i_reg_wen;
  assign ex.o_reg_waddr = (i_rst || wr_kill) ? '0 : ex.i_reg_waddr;
  assign ex.o_reg_wdata = i_rst ? '0 : wdata;
  assign ex.o_hilo_wen  = !i_rst && div_hw;
  assign ex.o_hi        = i_rst ? '0 : div_res.hi;
  assign ex.o_lo        = i_rst ? '0 : div_res.lo;
  assign ex.o_stall_req = !i_rst && div_stall;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed literal checks plus randomized traffic compared
// every cycle against a cycle-count/arithmetic model of the execute stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_if bus();
  ex_stage dut (.i_clk(clk), .i_rst(rst), .ex(bus));

  int total = 0;
  int bad   = 0;
  bit mdl_on = 1'b0;
  bit m_stall = 1'b0;  // model's expected stall for the last sampled cycle

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gpr_ref(logic [7:0] op, logic [2:0] sel, logic [31:0] a, logic [31:0] b);
    logic [63:0] ext;
    ext = {{32{b[31]}}, b} >> a[4:0];
    if (sel == EXE_RES_LOGIC) begin
      if (op == EXE_OR_OP)  return a | b;
      if (op == EXE_AND_OP) return a & b;
      if (op == EXE_XOR_OP) return a ^ b;
      if (op == EXE_NOR_OP) return ~(a | b);
    end else if (sel == EXE_RES_SHIFT) begin
      if (op == EXE_SLL_OP) return b << a[4:0];
      if (op == EXE_SRL_OP) return b >> a[4:0];
      if (op == EXE_SRA_OP) return ext[31:0];
    end
    return 32'h0;
  endfunction

  function automatic void div_ref(bit sgn, logic [31:0] a, logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    hi = 32'h0; lo = 32'h0;
    if (b != 32'h0) begin
      if (sgn) begin sa = $signed(a); sb = $signed(b); end
      else     begin sa = {32'h0, a}; sb = {32'h0, b}; end
      q = sa / sb;
      r = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // ---------------- model + per-cycle compare ----------------
  bit          m_run = 1'b0;
  int          m_ctd = 0;      // cycles remaining until the HI/LO write cycle
  logic [31:0] m_hi, m_lo;

  always @(negedge clk) begin : model
    logic [31:0] e_wd, e_hi, e_lo;
    logic [4:0]  e_wa;
    logic        e_wen, e_hw, e_st, kill;
    if (mdl_on) begin
      kill  = bus.i_flush || bus.i_alu_sel == EXE_RES_NOP || bus.i_alu_sel == EXE_RES_ARITH;
      e_wd  = gpr_ref(bus.i_alu_op, bus.i_alu_sel, bus.i_op_reg_0, bus.i_op_reg_1);
      e_wen = bus.i_reg_wen && !kill;
      e_wa  = kill ? 5'd0 : bus.i_reg_waddr;
      e_st = 1'b0; e_hw = 1'b0; e_hi = 32'h0; e_lo = 32'h0;
`ifdef EX_DIV_EN
      if (m_run && m_ctd > 0) e_st = 1'b1;
      else if (m_run) begin
        e_hw = !bus.i_flush;
        if (e_hw) begin e_hi = m_hi; e_lo = m_lo; end
      end else
        e_st = (bus.i_alu_op == EXE_DIV_OP || bus.i_alu_op == EXE_DIVU_OP) && !bus.i_flush;
      if (rst || bus.i_flush) m_run = 1'b0;
      else if (m_run) begin
        if (m_ctd == 0) m_run = 1'b0;
        else m_ctd--;
      end else if (e_st) begin
        m_run = 1'b1;
        m_ctd = (bus.i_op_reg_1 == 32'h0) ? 1 : 32;
        div_ref(bus.i_alu_op == EXE_DIV_OP, bus.i_op_reg_0, bus.i_op_reg_1, m_hi, m_lo);
      end
`endif
      if (rst) begin
        e_wd = 32'h0; e_wen = 1'b0; e_wa = 5'd0;
        e_st = 1'b0; e_hw = 1'b0; e_hi = 32'h0; e_lo = 32'h0;
      end
      m_stall = e_st;
      chk("m_reg_wen",   bus.o_reg_wen,   e_wen);
      chk("m_reg_waddr", bus.o_reg_waddr, e_wa);
      chk("m_reg_wdata", bus.o_reg_wdata, e_wd);
      chk("m_stall",     bus.o_stall_req, e_st);
      chk("m_hilo_wen",  bus.o_hilo_wen,  e_hw);
      chk("m_hi",        bus.o_hi,        e_hi);
      chk("m_lo",        bus.o_lo,        e_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(logic [7:0] op, logic [2:0] sel, logic [31:0] a, logic [31:0] b, logic fl);
    bus.i_alu_op    = op;
    bus.i_alu_sel   = sel;
    bus.i_op_reg_0  = a;
    bus.i_op_reg_1  = b;
    bus.i_reg_wen   = 1'b1;
    bus.i_reg_waddr = 5'($urandom_range(1, 31));
    bus.i_flush     = fl;
  endtask

`ifdef EX_DIV_EN
  // Issue a division, hold it while stalled, and check latency and result.
  task automatic run_div(string nm, logic [7:0] op, logic [31:0] a, logic [31:0] b,
                         int lat, logic [31:0] ehi, logic [31:0] elo);
    bit seen = 1'b0;
    issue(op, EXE_RES_ARITH, a, b, 1'b0);
    for (int k = 0; k <= lat + 5 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_hilo_wen === 1'b1) begin
        seen = 1'b1;
        chk({nm, "_lat"}, k, lat);
        chk({nm, "_hi"}, bus.o_hi, ehi);
        chk({nm, "_lo"}, bus.o_lo, elo);
        chk({nm, "_done_stall"}, bus.o_stall_req, 1'b0);
      end else begin
        chk({nm, "_stall"}, bus.o_stall_req, 1'b1);
        step();
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: no hilo_wen within %0d cycles", nm, lat + 5);
    end
    step();
    issue(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk({nm, "_pulse"}, bus.o_hilo_wen, 1'b0);
  endtask

  task automatic abort_div(string nm, bit use_rst);
    issue(EXE_DIVU_OP, EXE_RES_ARITH, 32'd100, 32'd7, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); chk({nm, "_stall"}, bus.o_stall_req, 1'b1);
      step();
    end
    if (use_rst) rst = 1'b1;
    else begin
      bus.i_flush = 1'b1;
      @(negedge clk); chk({nm, "_stall_t10"}, bus.o_stall_req, 1'b1);
    end
    step();
    rst = 1'b0;
    issue(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk({nm, "_stall_t11"}, bus.o_stall_req, 1'b0);
    chk({nm, "_hw_t11"}, bus.o_hilo_wen, 1'b0);
    for (int k = 0; k < 30; k++) begin
      step(); @(negedge clk);
      chk({nm, "_no_hw"}, bus.o_hilo_wen, 1'b0);
    end
  endtask
`endif

  task automatic rand_instr();
    logic [7:0] lops [4];
    logic [7:0] sops [3];
    int cls;
    lops = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP};
    sops = '{EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP};
    cls = $urandom_range(0, 9);
    issue(EXE_NOP_OP, EXE_RES_NOP, $urandom, $urandom, ($urandom_range(0, 9) == 0));
    bus.i_reg_wen = 1'($urandom_range(0, 3) != 0);
    if (cls <= 3) begin
      bus.i_alu_sel = EXE_RES_LOGIC; bus.i_alu_op = lops[$urandom_range(0, 3)];
    end else if (cls <= 6) begin
      bus.i_alu_sel = EXE_RES_SHIFT; bus.i_alu_op = sops[$urandom_range(0, 2)];
    end else if (cls <= 8) begin
      bus.i_alu_sel = EXE_RES_ARITH;
      bus.i_alu_op  = ($urandom_range(0, 1) != 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      if ($urandom_range(0, 7) == 0) bus.i_op_reg_1 = 32'h0;
      else if ($urandom_range(0, 7) == 0) begin
        bus.i_op_reg_0 = 32'h8000_0000; bus.i_op_reg_1 = 32'hFFFF_FFFF;
      end else if ($urandom_range(0, 1) != 0) bus.i_op_reg_1 = 32'($urandom_range(1, 1000));
    end else if (cls == 9 && $urandom_range(0, 1) != 0) begin
      bus.i_alu_sel = 3'b111; bus.i_alu_op = lops[$urandom_range(0, 3)];
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    issue(EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h0000_5678, 1'b0);
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_wen",   bus.o_reg_wen,   1'b0);
    chk("rst_waddr", bus.o_reg_waddr, 5'd0);
    chk("rst_wdata", bus.o_reg_wdata, 32'h0);
    chk("rst_stall", bus.o_stall_req, 1'b0);
    chk("rst_hw",    bus.o_hilo_wen,  1'b0);
    step();
    mdl_on = 1'b1;
    step();
    rst = 1'b0;

    issue(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h0F0F_0000, 1'b0);
    @(negedge clk);
    chk("or_wdata", bus.o_reg_wdata, 32'h0F0F_FF00);
    chk("or_wen",   bus.o_reg_wen,   1'b1);
    chk("or_stall", bus.o_stall_req, 1'b0);
    step();
    issue(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b0);
    @(negedge clk); chk("sra_wdata", bus.o_reg_wdata, 32'hF800_0000);
    step();
    issue(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b0);
    @(negedge clk); chk("srl_wdata", bus.o_reg_wdata, 32'h0800_0000);
    step();
    issue(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1);
    @(negedge clk);
    chk("flush_wen",   bus.o_reg_wen,   1'b0);
    chk("flush_waddr", bus.o_reg_waddr, 5'd0);
    step();

`ifdef EX_DIV_EN
    run_div("div_m7_2",   EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step();
    run_div("divu_x10_0", EXE_DIVU_OP, 32'h0000_0010, 32'd0, 2,  32'h0, 32'h0);
    step();
    run_div("div_ovf",    EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    step();
    run_div("divu_big",   EXE_DIVU_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'h1, 32'h7FFF_FFFC);
    step();
    abort_div("abort_flush", 1'b0);
    step();
    abort_div("abort_rst", 1'b1);
`else
    issue(EXE_DIVU_OP, EXE_RES_ARITH, 32'd9, 32'd3, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("nodiv_stall", bus.o_stall_req, 1'b0);
      chk("nodiv_hw",    bus.o_hilo_wen,  1'b0);
      chk("nodiv_wen",   bus.o_reg_wen,   1'b0);
      step();
    end
`endif

    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (m_stall) begin
        // decode holds the instruction; operand changes must be ignored
        bus.i_op_reg_0 = $urandom;
        bus.i_op_reg_1 = $urandom;
        bus.i_flush    = ($urandom_range(0, 39) == 0);
      end else
        rand_instr();
    end
    step();
    rst = 1'b0;
    issue(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
